pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Generates EX-operand forwarding selects.
- Detects load-use hazards and inserts one bubble.
- Tracks the multi-cycle multiply/divide unit (MDU) and stalls HI/LO consumers while it is busy.
- Squashes the wrong-path fetch after a taken branch. The branch is resolved in EX and the delay slot is kept.
- Sits beside the CPU datapath and drives stall/flush enables of the IF/ID and ID/EX pipeline registers.

Parameters:
MULT_LAT, 4, MDU cycles for MULT/MULTU (>=1)
DIV_LAT, 32, MDU cycles for DIV/DIVU (>=1)
CNT_W, 6, MDU latency counter width; must hold max(MULT_LAT,DIV_LAT)-1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
id_rs  in  5  rs of instruction in ID
id_rt  in  5  rt of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_uses_hilo  in  1  ID instruction is MFHI/MFLO/MTHI/MTLO or an MDU op
ex_rs  in  5  rs of instruction in EX
ex_rt  in  5  rt of instruction in EX
ex_rd  in  5  destination of instruction in EX
ex_is_load  in  1  EX instruction is a load
ex_branch_taken  in  1  taken branch/jump resolved in EX
mdu_start  in  1  MDU op issuing from EX this cycle
mdu_is_div  in  1  qualifies mdu_start: 1=divide, 0=multiply
exmem_rd  in  5  EX/MEM destination
exmem_wen  in  1  EX/MEM register write enable
memwb_rd  in  5  MEM/WB destination
memwb_wen  in  1  MEM/WB register write enable
fwd_a  out  2  EX operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
fwd_b  out  2  EX operand B select, same encoding
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID register
bubble_ex  out  1  load NOP into ID/EX
flush_if  out  1  squash IF/ID input (wrong-path fetch)
mdu_busy  out  1  MDU operation in flight
mdu_done  out  1  one-cycle pulse when an MDU op completes

Behaviour:
- Reset (reset==0 at posedge) clears state to RUN, counter to 0, flush_pending to 0 and mdu_done to 0. While reset is low, every output is forced to 0. Reset during MDU_BUSY aborts the operation and issues no mdu_done.
- Forwarding (combinational) for fwd_a:
  - 10 if exmem_wen, exmem_rd!=0 and exmem_rd==ex_rs.
  - else 01 if memwb_wen, memwb_rd!=0 and memwb_rd==ex_rs.
  - else 00.
  - EX/MEM wins when both match. fwd_b is identical, using ex_rt.
- Load-use (combinational) is true when ex_is_load, ex_rd!=0 and ((id_uses_rs and id_rs==ex_rd) or (id_uses_rt and id_rt==ex_rd)). It asserts stall_if, stall_id and bubble_ex for exactly one cycle; forwarding from MEM/WB resolves the following cycle.
- The MDU FSM has two states, RUN and MDU_BUSY.
  - In RUN, mdu_start loads the counter with (mdu_is_div ? DIV_LAT : MULT_LAT)-1 and moves to MDU_BUSY.
  - In MDU_BUSY, the counter decrements each cycle. When counter==0, the FSM returns to RUN and mdu_done is high in the next cycle (registered).
  - mdu_busy is 1 exactly while in MDU_BUSY, for LAT cycles.
  - mdu_start in MDU_BUSY is ignored. The design must never produce it, and a bench assertion checks for it.
- MDU stall is true when mdu_busy and id_uses_hilo. It asserts stall_if, stall_id and bubble_ex. The stall releases in the cycle mdu_done is high.
- stall_if = stall_id = bubble_ex = load-use OR MDU stall.
- Flush:
  - With no stall, ex_branch_taken asserts flush_if that cycle.
  - If ex_branch_taken coincides with a stall, set flush_pending. flush_if is then asserted on the first non-stall cycle and flush_pending clears.
  - flush_if is never asserted while stall_if is 1.
  - A second taken branch while flush_pending is set keeps a single pending flush.

Optional Feature:
STALL_CNT_EN:
- Defined: adds output stall_cycles[31:0]. It resets to 0, increments every cycle stall_if==1, and saturates at 32'hFFFFFFFF. It also adds flush_count[15:0], which increments on each flush_if, wraps, and resets to 0.
- Undefined: neither port nor the counters exist. All other behaviour is identical.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs=5, id_uses_rs=1 -> stall_if/stall_id/bubble_ex=1 for 1 cycle. Repeat with ex_rd=0 -> no stall.
- Forwarding: exmem_rd=8/wen=1, memwb_rd=8/wen=1, ex_rs=8 -> fwd_a=10. Drop exmem_wen -> fwd_a=01. Set ex_rt=0 with matching rd=0 -> fwd_b=00.
- DIV: mdu_start=1, mdu_is_div=1 in cycle t, id_uses_hilo=1 held -> mdu_busy=1 in cycles t+1..t+32, stall in the same cycles, mdu_done=1 and stall=0 in cycle t+33. MULT -> busy for 4 cycles.
- Branch during MDU stall: ex_branch_taken=1 in a stall cycle -> flush_if=0 during the stall, flush_if=1 in exactly the first non-stall cycle, then 0.
- Reset mid-op: reset=0 at cycle 10 of a DIV -> next cycle all outputs 0, no mdu_done afterwards. A new MULT after release completes in 4 cycles.
- STALL_CNT_EN defined: 3 load-use stalls plus one 4-cycle MULT stall -> stall_cycles=7, flush_count counts flush_if pulses.

Source files
------------

// File: rtl/pipe_hazard_if.sv
// Hazard-control bus between the pipeline datapath (master) and pipe_hazard_ctrl (slave).
// Defining STALL_CNT_EN adds the stall_cycles and flush_count statistics outputs.
interface pipe_hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_uses_hilo;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_rd;
    logic        ex_is_load;
    logic        ex_branch_taken;
    logic        mdu_start;
    logic        mdu_is_div;
    logic [4:0]  exmem_rd;
    logic        exmem_wen;
    logic [4:0]  memwb_rd;
    logic        memwb_wen;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        stall_if;
    logic        stall_id;
    logic        bubble_ex;
    logic        flush_if;
    logic        mdu_busy;
    logic        mdu_done;
`ifdef STALL_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_uses_hilo,
        output ex_rs, ex_rt, ex_rd, ex_is_load, ex_branch_taken,
        output mdu_start, mdu_is_div, exmem_rd, exmem_wen, memwb_rd, memwb_wen,
        input  fwd_a, fwd_b, stall_if, stall_id, bubble_ex, flush_if, mdu_busy, mdu_done
`ifdef STALL_CNT_EN
        , input stall_cycles, flush_count
`endif
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_uses_hilo,
        input  ex_rs, ex_rt, ex_rd, ex_is_load, ex_branch_taken,
        input  mdu_start, mdu_is_div, exmem_rd, exmem_wen, memwb_rd, memwb_wen,
        output fwd_a, fwd_b, stall_if, stall_id, bubble_ex, flush_if, mdu_busy, mdu_done
`ifdef STALL_CNT_EN
        , output stall_cycles, flush_count
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage MIPS pipeline: forwarding, load-use bubble,
// MDU busy tracking and branch squash. Optional STALL_CNT_EN adds stall/flush statistics.
module pipe_hazard_ctrl #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32,
    parameter int CNT_W    = 6
) (
    input  logic               clk,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

    typedef enum logic {RUN, MDU_BUSY} state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             mdu_done_reg;
    logic             flush_pending_reg;
    logic             flush_pending_next;

    logic             load_use;
    logic             mdu_stall;
    logic             stall;
    logic             flush_now;

    // Operand 0 is rs (fwd_a), operand 1 is rt (fwd_b); EX/MEM has priority over MEM/WB.
    logic [1:0][4:0]  ex_src;
    logic [1:0][1:0]  fwd_sel;

    assign ex_src[0] = bus.ex_rs;
    assign ex_src[1] = bus.ex_rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_sel[gi] =
                (bus.exmem_wen && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == ex_src[gi])) ? 2'b10 :
                (bus.memwb_wen && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == ex_src[gi])) ? 2'b01 :
                                                                                            2'b00;
        end
    endgenerate

    assign load_use = bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                      ((bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
                       (bus.id_uses_rt && (bus.id_rt == bus.ex_rd)));
    assign mdu_stall = (state_reg == MDU_BUSY) && bus.id_uses_hilo;
    assign stall     = load_use || mdu_stall;
    assign flush_now = !stall && (bus.ex_branch_taken || flush_pending_reg);

    // A branch resolved under a stall is remembered and squashed on the first free cycle.
    always_comb begin
        flush_pending_next = flush_pending_reg;
        if (!stall)
            flush_pending_next = 1'b0;
        else if (bus.ex_branch_taken)
            flush_pending_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg         <= RUN;
            cnt_reg           <= '0;
            mdu_done_reg      <= 1'b0;
            flush_pending_reg <= 1'b0;
        end else begin
            mdu_done_reg      <= 1'b0;
            flush_pending_reg <= flush_pending_next;
            case (state_reg)
                RUN: begin
                    if (bus.mdu_start) begin
                        cnt_reg   <= bus.mdu_is_div ? DIV_LOAD : MULT_LOAD;
                        state_reg <= MDU_BUSY;
                    end
                end
                MDU_BUSY: begin
                    if (cnt_reg == '0) begin
                        state_reg    <= RUN;
                        mdu_done_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: state_reg <= RUN;
            endcase
        end
    end

    // Every output is held low while reset is asserted.
    assign bus.fwd_a     = reset ? fwd_sel[0] : 2'b00;
    assign bus.fwd_b     = reset ? fwd_sel[1] : 2'b00;
    assign bus.stall_if  = reset && stall;
    assign bus.stall_id  = reset && stall;
    assign bus.bubble_ex = reset && stall;
    assign bus.flush_if  = reset && flush_now;
    assign bus.mdu_busy  = reset && (state_reg == MDU_BUSY);
    assign bus.mdu_done  = reset && mdu_done_reg;

`ifdef STALL_CNT_EN
    logic [31:0] stall_cycles_reg;
    logic [15:0] flush_count_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles_reg <= '0;
            flush_count_reg  <= '0;
        end else begin
            if (stall && (stall_cycles_reg != 32'hFFFF_FFFF))
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            if (flush_now)
                flush_count_reg <= flush_count_reg + 16'd1;
        end
    end

    assign bus.stall_cycles = reset ? stall_cycles_reg : 32'd0;
    assign bus.flush_count  = reset ? flush_count_reg  : 16'd0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MULT_LAT=4, DIV_LAT=32).
module tb_pipe_hazard_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pipe_hazard_ctrl_if bus();

    pipe_hazard_ctrl #(.MULT_LAT(4), .DIV_LAT(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The datapath must never issue an MDU op while the MDU is busy.
    always @(negedge clk) begin
        assert (!(reset && bus.mdu_start && bus.mdu_busy))
        else begin
            errors++;
            $display("FAIL mdu_start_while_busy: start=%b busy=%b required no overlap",
                     bus.mdu_start, bus.mdu_busy);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.id_rs = 5'd0;      bus.id_rt = 5'd0;
        bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0; bus.id_uses_hilo = 1'b0;
        bus.ex_rs = 5'd0;      bus.ex_rt = 5'd0;      bus.ex_rd = 5'd0;
        bus.ex_is_load = 1'b0; bus.ex_branch_taken = 1'b0;
        bus.mdu_start = 1'b0;  bus.mdu_is_div = 1'b0;
        bus.exmem_rd = 5'd0;   bus.exmem_wen = 1'b0;
        bus.memwb_rd = 5'd0;   bus.memwb_wen = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        clear_inputs();
        bus.exmem_rd = 5'd8; bus.exmem_wen = 1'b1; bus.ex_rs = 5'd8; bus.ex_rt = 5'd8;
        bus.ex_is_load = 1'b1; bus.ex_rd = 5'd4; bus.id_rs = 5'd4; bus.id_uses_rs = 1'b1;
        bus.ex_branch_taken = 1'b1;
        tick(); tick();
        checks++; if (bus.fwd_a !== 2'b00) begin errors++; $display("FAIL reset_fwd_a: got %b expected 00", bus.fwd_a); end
        checks++; if (bus.fwd_b !== 2'b00) begin errors++; $display("FAIL reset_fwd_b: got %b expected 00", bus.fwd_b); end
        checks++; if (bus.stall_if !== 1'b0) begin errors++; $display("FAIL reset_stall_if: got %b expected 0", bus.stall_if); end
        checks++; if (bus.flush_if !== 1'b0) begin errors++; $display("FAIL reset_flush_if: got %b expected 0", bus.flush_if); end
        checks++; if ({bus.mdu_busy, bus.mdu_done} !== 2'b00) begin errors++; $display("FAIL reset_mdu: got busy/done %b expected 00", {bus.mdu_busy, bus.mdu_done}); end
        clear_inputs();
        reset = 1'b1;
        tick();
        $display("reset: outputs held low while reset=0");
    endtask

    task automatic test_forwarding;
        clear_inputs();
        bus.exmem_rd = 5'd8; bus.exmem_wen = 1'b1; bus.memwb_rd = 5'd8; bus.memwb_wen = 1'b1;
        bus.ex_rs = 5'd8; bus.ex_rt = 5'd3;
        #1;
        checks++; if (bus.fwd_a !== 2'b10) begin errors++; $display("FAIL fwd_a_both: got %b expected 10", bus.fwd_a); end
        checks++; if (bus.fwd_b !== 2'b00) begin errors++; $display("FAIL fwd_b_nomatch: got %b expected 00", bus.fwd_b); end
        bus.exmem_wen = 1'b0;
        #1;
        checks++; if (bus.fwd_a !== 2'b01) begin errors++; $display("FAIL fwd_a_memwb: got %b expected 01", bus.fwd_a); end
        bus.exmem_wen = 1'b1; bus.exmem_rd = 5'd0; bus.memwb_rd = 5'd0; bus.ex_rt = 5'd0;
        #1;
        checks++; if (bus.fwd_b !== 2'b00) begin errors++; $display("FAIL fwd_b_r0: got %b expected 00", bus.fwd_b); end
        bus.exmem_rd = 5'd9; bus.ex_rt = 5'd9; bus.memwb_rd = 5'd8; bus.ex_rs = 5'd8;
        #1;
        checks++; if (bus.fwd_b !== 2'b10) begin errors++; $display("FAIL fwd_b_exmem: got %b expected 10", bus.fwd_b); end
        checks++; if (bus.fwd_a !== 2'b01) begin errors++; $display("FAIL fwd_a_memwb2: got %b expected 01", bus.fwd_a); end
        clear_inputs();
        tick();
        $display("forwarding: priority and r0 cases applied");
    endtask

    task automatic test_load_use;
        clear_inputs();
        bus.ex_is_load = 1'b1; bus.ex_rd = 5'd5; bus.id_rs = 5'd5; bus.id_uses_rs = 1'b1;
        #1;
        checks++; if ({bus.stall_if, bus.stall_id, bus.bubble_ex} !== 3'b111) begin errors++; $display("FAIL load_use_rs: got %b expected 111", {bus.stall_if, bus.stall_id, bus.bubble_ex}); end
        tick();
        // Load has moved to MEM/WB side; consumer now forwards instead of stalling.
        bus.ex_is_load = 1'b0; bus.ex_rd = 5'd0; bus.ex_rs = 5'd5; bus.memwb_rd = 5'd5; bus.memwb_wen = 1'b1;
        #1;
        checks++; if (bus.stall_if !== 1'b0) begin errors++; $display("FAIL load_use_release: got %b expected 0", bus.stall_if); end
        checks++; if (bus.fwd_a !== 2'b01) begin errors++; $display("FAIL load_use_fwd: got %b expected 01", bus.fwd_a); end
        clear_inputs();
        bus.ex_is_load = 1'b1; bus.ex_rd = 5'd0; bus.id_rs = 5'd0; bus.id_uses_rs = 1'b1;
        #1;
        checks++; if (bus.stall_if !== 1'b0) begin errors++; $display("FAIL load_use_r0: got %b expected 0", bus.stall_if); end
        bus.ex_rd = 5'd7; bus.id_rs = 5'd1; bus.id_rt = 5'd7; bus.id_uses_rt = 1'b1;
        #1;
        checks++; if (bus.bubble_ex !== 1'b1) begin errors++; $display("FAIL load_use_rt: got %b expected 1", bus.bubble_ex); end
        bus.id_uses_rt = 1'b0; bus.id_rs = 5'd7; bus.id_uses_rs = 1'b0;
        #1;
        checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL load_use_unused: got %b expected 0", bus.stall_id); end
        clear_inputs();
        tick();
        $display("load_use: one-cycle stall, r0 and unused-operand cases");
    endtask

    task automatic test_branch;
        clear_inputs();
        bus.ex_branch_taken = 1'b1;
        #1;
        checks++; if (bus.flush_if !== 1'b1) begin errors++; $display("FAIL branch_flush: got %b expected 1", bus.flush_if); end
        tick();
        bus.ex_branch_taken = 1'b0;
        #1;
        checks++; if (bus.flush_if !== 1'b0) begin errors++; $display("FAIL branch_flush_clear: got %b expected 0", bus.flush_if); end
        bus.ex_is_load = 1'b1; bus.ex_rd = 5'd3; bus.id_rs = 5'd3; bus.id_uses_rs = 1'b1; bus.ex_branch_taken = 1'b1;
        #1;
        checks++; if (bus.flush_if !== 1'b0) begin errors++; $display("FAIL branch_load_stall: got %b expected 0", bus.flush_if); end
        tick();
        clear_inputs();
        #1;
        checks++; if (bus.flush_if !== 1'b1) begin errors++; $display("FAIL branch_pending: got %b expected 1", bus.flush_if); end
        tick();
        checks++; if (bus.flush_if !== 1'b0) begin errors++; $display("FAIL branch_pending_clear: got %b expected 0", bus.flush_if); end
        $display("branch: immediate and load-stall-deferred flush");
    endtask

    task automatic test_mdu_op(input bit is_div, input int lat);
        int bad_busy;
        int bad_stall;
        clear_inputs();
        bad_busy = 0; bad_stall = 0;
        bus.mdu_start = 1'b1; bus.mdu_is_div = is_div; bus.id_uses_hilo = 1'b1;
        #1;
        checks++; if (bus.mdu_busy !== 1'b0) begin errors++; $display("FAIL mdu_issue_busy: got %b expected 0", bus.mdu_busy); end
        tick();
        bus.mdu_start = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            #1;
            checks++;
            if ({bus.mdu_busy, bus.mdu_done} !== 2'b10) begin
                errors++; bad_busy++;
                $display("FAIL mdu_busy_c%0d: got busy/done %b expected 10", k, {bus.mdu_busy, bus.mdu_done});
            end
            checks++;
            if ({bus.stall_if, bus.stall_id, bus.bubble_ex} !== 3'b111) begin
                errors++; bad_stall++;
                $display("FAIL mdu_stall_c%0d: got %b expected 111", k, {bus.stall_if, bus.stall_id, bus.bubble_ex});
            end
            tick();
        end
        #1;
        checks++; if ({bus.mdu_busy, bus.mdu_done} !== 2'b01) begin errors++; $display("FAIL mdu_done: got busy/done %b expected 01", {bus.mdu_busy, bus.mdu_done}); end
        checks++; if (bus.stall_if !== 1'b0) begin errors++; $display("FAIL mdu_release: got %b expected 0", bus.stall_if); end
        tick();
        checks++; if (bus.mdu_done !== 1'b0) begin errors++; $display("FAIL mdu_done_pulse: got %b expected 0", bus.mdu_done); end
        clear_inputs();
        $display("mdu %s: latency %0d, busy errors %0d, stall errors %0d", is_div ? "div" : "mult", lat, bad_busy, bad_stall);
    endtask

    task automatic test_branch_during_stall;
        clear_inputs();
        bus.mdu_start = 1'b1; bus.mdu_is_div = 1'b0; bus.id_uses_hilo = 1'b1;
        tick();
        bus.mdu_start = 1'b0; bus.ex_branch_taken = 1'b1;
        #1;
        checks++; if ({bus.stall_if, bus.flush_if} !== 2'b10) begin errors++; $display("FAIL bstall_c1: got stall/flush %b expected 10", {bus.stall_if, bus.flush_if}); end
        tick();
        #1;
        checks++; if (bus.flush_if !== 1'b0) begin errors++; $display("FAIL bstall_c2: got %b expected 0", bus.flush_if); end
        tick();
        bus.ex_branch_taken = 1'b0;
        #1;
        checks++; if (bus.flush_if !== 1'b0) begin errors++; $display("FAIL bstall_c3: got %b expected 0", bus.flush_if); end
        tick();
        checks++; if ({bus.stall_if, bus.flush_if} !== 2'b10) begin errors++; $display("FAIL bstall_c4: got stall/flush %b expected 10", {bus.stall_if, bus.flush_if}); end
        tick();
        checks++; if ({bus.stall_if, bus.flush_if, bus.mdu_done} !== 3'b011) begin errors++; $display("FAIL bstall_c5: got stall/flush/done %b expected 011", {bus.stall_if, bus.flush_if, bus.mdu_done}); end
        tick();
        checks++; if (bus.flush_if !== 1'b0) begin errors++; $display("FAIL bstall_single: got %b expected 0", bus.flush_if); end
        clear_inputs();
        tick();
        $display("branch_during_stall: single deferred flush after MULT stall");
    endtask

    task automatic test_reset_mid_op;
        int done_seen;
        int busy_seen;
        clear_inputs();
        done_seen = 0; busy_seen = 0;
        bus.mdu_start = 1'b1; bus.mdu_is_div = 1'b1;
        tick();
        bus.mdu_start = 1'b0;
        repeat (9) tick();
        reset = 1'b0;
        tick();
        checks++; if ({bus.mdu_busy, bus.mdu_done, bus.stall_if, bus.flush_if, bus.fwd_a, bus.fwd_b} !== 8'd0) begin
            errors++; $display("FAIL reset_mid_op: got %b expected 00000000", {bus.mdu_busy, bus.mdu_done, bus.stall_if, bus.flush_if, bus.fwd_a, bus.fwd_b});
        end
        reset = 1'b1;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (bus.mdu_done) done_seen++;
            if (bus.mdu_busy) busy_seen++;
            tick();
        end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d done pulses expected 0", done_seen); end
        checks++; if (busy_seen !== 0) begin errors++; $display("FAIL abort_no_busy: got %0d busy cycles expected 0", busy_seen); end
        $display("reset_mid_op: DIV aborted at cycle 10");
        test_mdu_op(1'b0, 4);
    endtask

`ifdef STALL_CNT_EN
    task automatic test_stall_counters;
        clear_inputs();
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.ex_is_load = 1'b1; bus.ex_rd = 5'd6; bus.id_rt = 5'd6; bus.id_uses_rt = 1'b1;
            tick();
            clear_inputs();
            tick();
        end
        bus.mdu_start = 1'b1; bus.mdu_is_div = 1'b0; bus.id_uses_hilo = 1'b1;
        tick();
        bus.mdu_start = 1'b0;
        repeat (5) tick();
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            bus.ex_branch_taken = 1'b1;
            tick();
            bus.ex_branch_taken = 1'b0;
            tick();
        end
        checks++; if (bus.stall_cycles !== 32'd7) begin errors++; $display("FAIL stall_cycles: got %0d expected 7", bus.stall_cycles); end
        checks++; if (bus.flush_count !== 16'd2) begin errors++; $display("FAIL flush_count: got %0d expected 2", bus.flush_count); end
        $display("stall_counters: stall_cycles=%0d flush_count=%0d", bus.stall_cycles, bus.flush_count);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mdu_op(1'b0, 4);
        test_mdu_op(1'b1, 32);
        test_branch_during_stall();
        test_reset_mid_op();
`ifdef STALL_CNT_EN
        test_stall_counters();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
